// File: rtl/alu_operand_sequencer.sv
// Purpose : collects operand A, operand B and op code F from a shared switch field, one value per
//           debounced enter press, then presents {A,B,F} to the ALU stage.
// Latency : a btn rise is captured 3+DEBOUNCE_CYCLES clk_2 edges later (2-FF sync + debounce + edge detect).
// Backpressure: op_valid and the operands hold until op_ready is seen; enter presses during ISSUE are dropped.
//
// Ports:
//   clk_2      system clock, all state on rising edge
//   reset      asynchronous active-high reset
//   din        data switches, sampled on an accepted enter
//   btn        raw enter button (asynchronous, may bounce)
//   op_ready   ALU stage can accept an operand set
//   op_valid   op_a/op_b/op_f hold a complete set
//   op_a/op_b  operands
//   op_f       op code (00 add, 01 sub, 10 and, 11 or)
//   state_led  one-hot entry stage, 111 while issuing
module alu_operand_sequencer #(
    parameter int NBITS_OP        = 3,
    parameter int NBITS_F         = 2,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [NBITS_OP-1:0] din,
    input  logic                btn,
    input  logic                op_ready,
    output logic                op_valid,
    output logic [NBITS_OP-1:0] op_a,
    output logic [NBITS_OP-1:0] op_b,
    output logic [NBITS_F-1:0]  op_f,
    output logic [2:0]          state_led
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] LED_GET_A = 3'b001;
    localparam logic [2:0] LED_GET_B = 3'b010;
    localparam logic [2:0] LED_GET_F = 3'b100;
    localparam logic [2:0] LED_ISSUE = 3'b111;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        GET_F = 2'd2,
        ISSUE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button synchroniser: btn is fully asynchronous to clk_2.
    // ------------------------------------------------------------------
    logic btn_meta;
    logic btn_s;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a new level must persist DEBOUNCE_CYCLES consecutive edges
    // before 'stable' follows it. Any return to the old level restarts the
    // count, so short pulses and bounces never reach 'stable'.
    // ------------------------------------------------------------------
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            stable_q <= stable;
            if (btn_s != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= btn_s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // One-cycle pulse on the debounced rising edge only; releases are ignored.
    logic enter;
    assign enter = stable & ~stable_q;

    // ------------------------------------------------------------------
    // Entry FSM with registered outputs. Each operand has its own stage, so
    // op_a/op_b cannot move while a set is being offered downstream.
    // ------------------------------------------------------------------
    state_t state;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state     <= GET_A;
            op_a      <= '0;
            op_b      <= '0;
            op_f      <= '0;
            op_valid  <= 1'b0;
            state_led <= LED_GET_A;
        end else begin
            case (state)
                GET_A: begin
                    if (enter) begin
                        op_a      <= din;
                        state     <= GET_B;
                        state_led <= LED_GET_B;
                    end
                end
                GET_B: begin
                    if (enter) begin
                        op_b      <= din;
                        state     <= GET_F;
                        state_led <= LED_GET_F;
                    end
                end
                GET_F: begin
                    if (enter) begin
                        // Only the low bits encode an op; the rest of the switches are don't-care.
                        op_f      <= din[NBITS_F-1:0];
                        op_valid  <= 1'b1;
                        state     <= ISSUE;
                        state_led <= LED_ISSUE;
                    end
                end
                ISSUE: begin
                    // enter is deliberately ignored here, including on the handshake edge.
                    if (op_valid && op_ready) begin
                        op_valid  <= 1'b0;
                        state     <= GET_A;
                        state_led <= LED_GET_A;
                    end
                end
                default: begin
                    op_valid  <= 1'b0;
                    state     <= GET_A;
                    state_led <= LED_GET_A;
                end
            endcase
        end
    end

endmodule
